// File: rtl/store_merge_if.sv
// Store-merge request/memory bus bundle.
// The slave modport is the store_merge view; the master modport is the requester/memory view.
interface store_merge_if #(
   parameter int unsigned ADDR_W = 64
);
   localparam int unsigned DATA_W = 64;

   logic              start;
   logic [1:0]        SELECT;
   logic [ADDR_W-1:0] ADDR;
   logic [DATA_W-1:0] B;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic              mem_wr;
   logic [DATA_W-1:0] mem_wdata;
   logic              busy;
   logic              done;
   logic              misaligned;

   modport slave (
      input  start, SELECT, ADDR, B, mem_rdata, mem_ready,
      output mem_addr, mem_rd, mem_wr, mem_wdata, busy, done, misaligned
   );

   modport master (
      output start, SELECT, ADDR, B, mem_rdata, mem_ready,
      input  mem_addr, mem_rd, mem_wr, mem_wdata, busy, done, misaligned
   );
endinterface

// File: rtl/store_merge.sv
// Sub-doubleword store via read-modify-write of the enclosing aligned doubleword.
// Doubleword stores skip the read. Misaligned requests raise a one-cycle error pulse.
module store_merge #(
   parameter int unsigned ADDR_W = 64
) (
   input  logic           clk,
   input  logic           reset_n,
   store_merge_if.slave   bus
);
   localparam int unsigned DATA_W = 64;

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t            state_q, state_d;
   logic [1:0]        sel_q, sel_d;
   logic [2:0]        off_q, off_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              rd_q, wr_q, busy_q, done_q, mis_q, mis_d;
   logic              misaligned_c;
   logic [DATA_W-1:0] size_mask_c, lane_mask_c, merged_c;

   // Alignment of the incoming request, judged on the live inputs at start.
   always_comb begin
      misaligned_c = 1'b0;
      unique case (bus.SELECT)
         2'b00:   misaligned_c = (bus.ADDR[2:0] != 3'b000);
         2'b01:   misaligned_c = (bus.ADDR[1:0] != 2'b00);
         2'b10:   misaligned_c = bus.ADDR[0];
         default: misaligned_c = 1'b0;
      endcase
   end

   // Replace the addressed byte lanes of the read doubleword with the store data.
   always_comb begin
      size_mask_c = {DATA_W{1'b1}};
      unique case (sel_q)
         2'b01:   size_mask_c = DATA_W'(64'h0000_0000_FFFF_FFFF);
         2'b10:   size_mask_c = DATA_W'(64'h0000_0000_0000_FFFF);
         2'b11:   size_mask_c = DATA_W'(64'h0000_0000_0000_00FF);
         default: size_mask_c = {DATA_W{1'b1}};
      endcase
      lane_mask_c = size_mask_c << {off_q, 3'b000};
      merged_c    = (bus.mem_rdata & ~lane_mask_c) | ((b_q << {off_q, 3'b000}) & lane_mask_c);
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      off_d   = off_q;
      b_d     = b_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      mis_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (misaligned_c) begin
                  mis_d = 1'b1;
               end else begin
                  sel_d  = bus.SELECT;
                  off_d  = bus.ADDR[2:0];
                  b_d    = bus.B;
                  addr_d = {bus.ADDR[ADDR_W-1:3], 3'b000};
                  if (bus.SELECT == 2'b00) begin
                     wdata_d = bus.B;
                     state_d = WRITE;
                  end else begin
                     state_d = READ;
                  end
               end
            end
         end
         READ: begin
            if (bus.mem_ready) begin
               wdata_d = merged_c;
               state_d = WRITE;
            end
         end
         WRITE: begin
            if (bus.mem_ready) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs; outputs track the state being entered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         sel_q   <= 2'b00;
         off_q   <= 3'b000;
         b_q     <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         off_q   <= off_d;
         b_q     <= b_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd_q    <= (state_d == READ);
         wr_q    <= (state_d == WRITE);
         busy_q  <= (state_d != IDLE);
         done_q  <= (state_d == DONE);
         mis_q   <= mis_d;
      end
   end

   assign bus.mem_addr   = addr_q;
   assign bus.mem_wdata  = wdata_q;
   assign bus.mem_rd     = rd_q;
   assign bus.mem_wr     = wr_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.misaligned = mis_q;
endmodule
